clock_time_controller: RTL and testbench

Timekeeping and time-set controller for the digital clock. It consumes the 1 Hz square wave from the 50 MHz prescaler and keeps hours, minutes and seconds. A three-state mode FSM driven by two debounced buttons sequences the user setting the time. While setting, it holds the prescaler in reset so the seconds phase restarts cleanly when setting ends.

---
 rtl/clock_time_controller.sv | 170 +++++++++++++++++
 tb/tb_clock_time_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_controller.sv
// Hours/minutes/seconds timekeeper with a RUN/SET_HR/SET_MIN set FSM; 12 h mode under CLOCK_CTRL_12H_EN.
// Latency: every input event is visible on the registered outputs one clk after it is sampled.
// Backpressure: none; inputs are levels sampled every cycle, presc_rst holds the prescaler while setting.
module clock_time_controller #(
    parameter int INIT_HOUR = 12,
    parameter int INIT_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       presc_rst,
    output logic [1:0] mode,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       pm,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       sec_q, mode_q, inc_q;
    logic       tick, mode_ev, inc_ev;
    logic [4:0] hour_nxt, hour_inc_val;
    logic [5:0] minute_nxt, second_nxt;
    logic       hour_step, last_hour, day_nxt;

    assign tick    = sec_in & ~sec_q;
    assign mode_ev = btn_mode & ~mode_q;
    assign inc_ev  = btn_inc & ~inc_q;
    assign mode    = state;

    // sec_q resets high so a prescaler sitting at 1 does not look like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q  <= 1'b1;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            sec_q  <= sec_in;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mode_ev) begin
            case (state)
                RUN:     state_nxt = SET_HR;
                SET_HR:  state_nxt = SET_MIN;
                SET_MIN: state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        hour_inc_val = hour + 5'd1;
        last_hour    = 1'b0;
`ifdef CLOCK_CTRL_12H_EN
        if (hour == 5'd12) begin
            hour_inc_val = 5'd1;
        end
        last_hour = (hour == 5'd11) && pm;
`else
        if (hour == 5'd23) begin
            hour_inc_val = 5'd0;
        end
        last_hour = (hour == 5'd23);
`endif
    end

    // A mode event pre-empts both the tick and the increment in the same cycle
    always_comb begin
        hour_step  = 1'b0;
        minute_nxt = minute;
        second_nxt = second;
        day_nxt    = 1'b0;
        if (mode_ev) begin
            if (state == RUN) begin
                second_nxt = 6'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        if (second == 6'd59) begin
                            second_nxt = 6'd0;
                            if (minute == 6'd59) begin
                                minute_nxt = 6'd0;
                                hour_step  = 1'b1;
                                day_nxt    = last_hour;
                            end else begin
                                minute_nxt = minute + 6'd1;
                            end
                        end else begin
                            second_nxt = second + 6'd1;
                        end
                    end
                end
                SET_HR: begin
                    if (inc_ev) begin
                        hour_step = 1'b1;
                    end
                end
                SET_MIN: begin
                    if (inc_ev) begin
                        minute_nxt = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                    end
                end
                default: ;
            endcase
        end
        hour_nxt = hour_step ? hour_inc_val : hour;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour      <= 5'(INIT_HOUR);
            minute    <= 6'(INIT_MIN);
            second    <= 6'd0;
            day_pulse <= 1'b0;
            presc_rst <= 1'b0;
        end else begin
            hour      <= hour_nxt;
            minute    <= minute_nxt;
            second    <= second_nxt;
            day_pulse <= day_nxt;
            presc_rst <= (state_nxt != RUN);
        end
    end

`ifdef CLOCK_CTRL_12H_EN
    logic pm_q, pm_nxt;

    // pm flips on every 11 -> 12 step, whether from a rollover or a set increment
    always_comb begin
        pm_nxt = pm_q ^ (hour_step && (hour == 5'd11));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q <= 1'b0;
        end else begin
            pm_q <= pm_nxt;
        end
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller: a reference model pushes expected outputs into a
// scoreboard queue as each cycle's stimulus is driven; they are popped and compared one clk later.
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sec_in = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       presc_rst;
    logic [1:0] mode;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       pm;
    logic       day_pulse;

    always #5 clk = ~clk;

    clock_time_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_in    (sec_in),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .presc_rst (presc_rst),
        .mode      (mode),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .pm        (pm),
        .day_pulse (day_pulse)
    );

`ifdef CLOCK_CTRL_12H_EN
    localparam int HR_INCS_TO_LAST = 23;
    localparam int MIDNIGHT_HR     = 12;
`else
    localparam int HR_INCS_TO_LAST = 11;
    localparam int MIDNIGHT_HR     = 0;
`endif

    typedef struct {
        int mode;
        int hour;
        int minute;
        int second;
        int pm;
        int presc;
        int day;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    int m_mode, m_hour, m_min, m_sec, m_pm, m_presc, m_day;
    logic p_sec, p_mode, p_inc;

    task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.mode   = m_mode;
        e.hour   = m_hour;
        e.minute = m_min;
        e.second = m_sec;
        e.pm     = m_pm;
        e.presc  = m_presc;
        e.day    = m_day;
        sbq.push_back(e);
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(tag, "mode",      mode,      e.mode);
            chk(tag, "hour",      hour,      e.hour);
            chk(tag, "minute",    minute,    e.minute);
            chk(tag, "second",    second,    e.second);
            chk(tag, "pm",        pm,        e.pm);
            chk(tag, "presc_rst", presc_rst, e.presc);
            chk(tag, "day_pulse", day_pulse, e.day);
        end
    endtask

    task automatic model_hour_step(bit run);
`ifdef CLOCK_CTRL_12H_EN
        if (m_hour == 12) begin
            m_hour = 1;
        end else begin
            if (m_hour == 11) begin
                m_pm = 1 - m_pm;
                if (run && m_pm == 0) m_day = 1;
            end
            m_hour++;
        end
`else
        if (m_hour == 23) begin
            m_hour = 0;
            if (run) m_day = 1;
        end else begin
            m_hour++;
        end
`endif
    endtask

    task automatic model_step(logic s, logic bm, logic bi);
        bit t, mev, iev;
        t   = s && !p_sec;
        mev = bm && !p_mode;
        iev = bi && !p_inc;
        m_day = 0;
        if (mev) begin
            if (m_mode == 0) m_sec = 0;
            m_mode = (m_mode == 2) ? 0 : m_mode + 1;
        end else if (m_mode == 0 && t) begin
            if (m_sec < 59) begin
                m_sec++;
            end else begin
                m_sec = 0;
                if (m_min < 59) m_min++;
                else begin
                    m_min = 0;
                    model_hour_step(1);
                end
            end
        end else if (m_mode == 1 && iev) begin
            model_hour_step(0);
        end else if (m_mode == 2 && iev) begin
            m_min = (m_min + 1) % 60;
        end
        m_presc = (m_mode != 0) ? 1 : 0;
        p_sec  = s;
        p_mode = bm;
        p_inc  = bi;
    endtask

    // Called at posedge+1: drive, predict, advance one clk, compare at posedge+1
    task automatic cyc(string tag, logic s, logic bm, logic bi);
        sec_in   = s;
        btn_mode = bm;
        btn_inc  = bi;
        model_step(s, bm, bi);
        push_exp();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic do_reset(string tag);
        sec_in   = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        m_mode = 0; m_hour = 12; m_min = 0; m_sec = 0;
        m_pm = 0; m_presc = 0; m_day = 0;
        p_sec = 1'b1; p_mode = 1'b0; p_inc = 1'b0;
        push_exp();
        #2;
        rst_n = 1'b0;
        #1;
        pop_check(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode(string tag);
        cyc(tag, 1'b1, 1'b1, 1'b0);
        cyc(tag, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_inc(string tag);
        cyc(tag, 1'b1, 1'b0, 1'b1);
        cyc(tag, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sec_edge(string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0);
        cyc(tag, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");
        cyc("post_reset", 1'b1, 1'b0, 1'b0);
        chk("reset_const", "hour", hour, 12);
        chk("reset_const", "mode", mode, 0);

        for (int i = 0; i < 3; i++) sec_edge("sec_count");
        chk("three_ticks", "second", second, 3);

        press_mode("enter_set_hr");
        chk("enter_set_hr", "presc_rst", presc_rst, 1);
        for (int i = 0; i < 13; i++) press_inc("hr_inc");
        chk("hr_inc13", "hour", hour, 1);

        // Simultaneous mode and inc edges: mode wins, hour must not move
        cyc("simul", 1'b1, 1'b1, 1'b1);
        cyc("simul", 1'b1, 1'b0, 1'b0);
        chk("simul_const", "mode", mode, 2);
        for (int i = 0; i < 61; i++) press_inc("min_inc");
        chk("min_inc61", "minute", minute, 1);

        for (int i = 0; i < 100; i++) cyc("hold_inc", 1'b1, 1'b0, 1'b1);
        cyc("hold_inc", 1'b1, 1'b0, 1'b0);
        chk("hold_inc_const", "minute", minute, 2);

        sec_edge("tick_in_set");
        chk("tick_in_set_const", "second", second, 0);

        do_reset("reset_in_set");
        chk("reset_in_set_const", "presc_rst", presc_rst, 0);

        press_mode("roll_set");
        for (int i = 0; i < HR_INCS_TO_LAST; i++) press_inc("roll_hr");
        press_mode("roll_set");
        for (int i = 0; i < 59; i++) press_inc("roll_min");
        cyc("exit_set", 1'b1, 1'b1, 1'b0);
        chk("exit_set_const", "presc_rst", presc_rst, 0);
        cyc("exit_set", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) sec_edge("roll_sec");
        chk("pre_roll_const", "second", second, 59);
        sec_edge("rollover");
        chk("rollover_const", "hour", hour, MIDNIGHT_HR);
        chk("rollover_const", "day_pulse", day_pulse, 1);
        cyc("after_roll", 1'b1, 1'b0, 1'b0);
        chk("after_roll_const", "day_pulse", day_pulse, 0);

        // Tick and mode edge together in RUN: enters SET_HR, second cleared
        sec_edge("pre_tick_mode");
        cyc("tick_mode", 1'b0, 1'b0, 1'b0);
        cyc("tick_mode", 1'b1, 1'b1, 1'b0);
        chk("tick_mode_const", "second", second, 0);
        cyc("tick_mode", 1'b1, 1'b0, 1'b0);
        press_mode("leave");
        press_mode("leave");
        cyc("final", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
